// File: rtl/test11_pkg.sv
// Shared types, state encoding and defaults for the mkTest11 adder arbiter.
package test11_pkg;

  localparam int unsigned DEF_WAIT_LIMIT = 255;
  localparam int unsigned DEF_CNT_W      = 16;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } ts_t;

  typedef struct packed {
    logic [31:0] sum;
    logic        cry;
  } tsum_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  function automatic logic [63:0] ts_pack(input ts_t v);
    return {v.a, v.b};
  endfunction

  function automatic ts_t ts_unpack(input logic [63:0] v);
    ts_t r;
    r.a = v[63:32];
    r.b = v[31:0];
    return r;
  endfunction

  // TSum packing: sum in [32:1], carry in [0]
  function automatic logic [32:0] tsum_pack(input tsum_t v);
    return {v.sum, v.cry};
  endfunction

  function automatic tsum_t tsum_unpack(input logic [32:0] v);
    tsum_t r;
    r.sum = v[32:1];
    r.cry = v[0];
    return r;
  endfunction

endpackage

// File: rtl/test11_add_arbiter_rr_arb2.sv
// Two-way round-robin grant; last_grant updates only when the grant is accepted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic       o_gnt_valid,
  output logic       o_gnt_id
);

  logic r_last;

  always_comb begin
    o_gnt_valid = |i_req;
    o_gnt_id    = 1'b0;
    case (i_req)
      2'b01:   o_gnt_id = 1'b0;
      2'b10:   o_gnt_id = 1'b1;
      2'b11:   o_gnt_id = ~r_last;
      default: o_gnt_id = 1'b0;
    endcase
  end

  // Reset to 1 so requester 0 wins the first contended grant
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (i_accept) begin
      r_last <= o_gnt_id;
    end
  end

endmodule

// File: rtl/test11_add_arbiter.sv
// Round-robin front end sharing one mkTest11 adder between two requesters.
module test11_add_arbiter
  import test11_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = DEF_WAIT_LIMIT,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [31:0]      resp_sum,
  output logic             resp_cry,
  output logic             resp_err,
  input  logic             RDY_add,
  output logic             EN_add,
  output logic [31:0]      add_s_a,
  output logic [31:0]      add_s_b,
  input  logic             RDY_sum,
  input  logic [31:0]      sum_sum,
  input  logic             sum_cry,
  output logic             busy,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam int unsigned TW = $clog2(WAIT_LIMIT + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  ts_t              r_op;
  tsum_t            r_res;
  tsum_t            w_sum_in;
  logic             r_err;
  logic             r_gid;
  logic [TW-1:0]    r_timer;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic             w_gnt_valid;
  logic             w_gnt_id;
  logic             w_hs;
  logic             w_en_add;
  logic             w_take;
  logic             w_timeout;
  logic [1:0]       w_req_ready;
  logic [1:0]       w_resp_valid;
  logic [1:0]       w_resp_rdy;

  assign w_resp_rdy = {resp1_ready, resp0_ready};
  assign w_sum_in   = tsum_unpack({sum_sum, sum_cry});

  rr_arb2 u_arb (
    .clk         (CLK),
    .rst_n       (RST_N),
    .i_req       ({req1_valid, req0_valid}),
    .i_accept    (w_hs),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_id    (w_gnt_id)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_hs         = 1'b0;
    w_en_add     = 1'b0;
    w_take       = 1'b0;
    w_timeout    = 1'b0;
    w_req_ready  = '0;
    w_resp_valid = '0;
    case (r_state)
      IDLE: begin
        if (w_gnt_valid) begin
          w_req_ready[w_gnt_id] = 1'b1;
          w_hs                  = 1'b1;
          w_state_nxt           = ISSUE;
        end
      end
      ISSUE: begin
        w_en_add = RDY_add;
        if (RDY_add) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (RDY_sum) begin
          w_state_nxt = RESP;
        end else if (r_timer == TW'(WAIT_LIMIT - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        w_resp_valid[r_gid] = 1'b1;
        if (w_resp_rdy[r_gid]) begin
          w_take      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // Handshake outputs are held low while reset is asserted
    if (!RST_N) begin
      w_hs         = 1'b0;
      w_en_add     = 1'b0;
      w_take       = 1'b0;
      w_req_ready  = '0;
      w_resp_valid = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_op    <= '0;
      r_gid   <= 1'b0;
      r_res   <= '0;
      r_err   <= 1'b0;
      r_timer <= '0;
      r_cnt0  <= '0;
      r_cnt1  <= '0;
    end else begin
      if (w_hs) begin
        r_op  <= w_gnt_id ? ts_unpack({req1_a, req1_b}) : ts_unpack({req0_a, req0_b});
        r_gid <= w_gnt_id;
      end
      // Timer only matters in WAIT; the final increment on exit cannot overflow TW
      if (w_en_add) begin
        r_timer <= '0;
      end else if (r_state == WAIT) begin
        r_timer <= r_timer + TW'(1);
      end
      if (r_state == WAIT) begin
        if (RDY_sum) begin
          r_res <= w_sum_in;
          r_err <= 1'b0;
        end else if (w_timeout) begin
          r_res <= '0;
          r_err <= 1'b1;
        end
      end
      if (w_take && !r_err) begin
        if (r_gid) begin
          if (r_cnt1 != '1) r_cnt1 <= r_cnt1 + CNT_W'(1);
        end else begin
          if (r_cnt0 != '1) r_cnt0 <= r_cnt0 + CNT_W'(1);
        end
      end
    end
  end

  assign req0_ready           = w_req_ready[0];
  assign req1_ready           = w_req_ready[1];
  assign resp0_valid          = w_resp_valid[0];
  assign resp1_valid          = w_resp_valid[1];
  assign {resp_sum, resp_cry} = tsum_pack(r_res);
  assign resp_err             = r_err;
  assign EN_add               = w_en_add;
  assign {add_s_a, add_s_b}   = ts_pack(r_op);
  assign busy                 = (r_state != IDLE);
  assign cnt0                 = r_cnt0;
  assign cnt1                 = r_cnt1;

endmodule

// File: tb/tb_test11_add_arbiter.sv
// Self-checking bench for test11_add_arbiter with a behavioural adder and response scoreboard.
module tb_test11_add_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [31:0] resp_sum;
  logic        resp_cry, resp_err;
  logic        RDY_add, EN_add;
  logic [31:0] add_s_a, add_s_b;
  logic        RDY_sum;
  logic [31:0] sum_sum;
  logic        sum_cry;
  logic        busy;
  logic [1:0]  cnt0, cnt1;

  always #5 CLK = ~CLK;

  test11_add_arbiter #(.WAIT_LIMIT(8), .CNT_W(2)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_sum(resp_sum), .resp_cry(resp_cry), .resp_err(resp_err),
    .RDY_add(RDY_add), .EN_add(EN_add), .add_s_a(add_s_a), .add_s_b(add_s_b),
    .RDY_sum(RDY_sum), .sum_sum(sum_sum), .sum_cry(sum_cry),
    .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
  );

  // Adder model: result valid adder_lat cycles after EN_add; 0 means never
  int unsigned adder_lat = 2;
  int unsigned m_cd = 0;
  logic [31:0] m_sum = '0;
  logic        m_cry = 1'b0;
  always @(posedge CLK) begin
    if (EN_add) begin
      {m_cry, m_sum} <= {1'b0, add_s_a} + {1'b0, add_s_b};
      m_cd           <= adder_lat;
    end else if (m_cd != 0) begin
      m_cd <= m_cd - 1;
    end
  end
  assign RDY_sum = (m_cd == 1);
  assign sum_sum = m_sum;
  assign sum_cry = m_cry;

  typedef struct {
    bit          id;
    logic [31:0] sum;
    logic        cry;
    logic        err;
  } sb_t;

  typedef struct {
    bit          id;
    logic [31:0] a;
    logic [31:0] b;
    int unsigned lat;
    logic [31:0] sum;
    logic        cry;
  } vec_t;

  sb_t         sb[$];
  bit          grant_q[$];
  int          n_chk = 0;
  int          n_err = 0;
  int unsigned hs_cnt = 0, resp_cnt = 0, en_cnt = 0;
  int unsigned exp_cnt0 = 0, exp_cnt1 = 0;
  bit          exp_timeout = 0;
  logic [31:0] last_add_a, last_add_b, last_sum;
  logic        last_cry, last_err;
  bit          last_id;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input bit id, input logic [31:0] a, input logic [31:0] b);
    sb_t e;
    logic [32:0] t;
    t     = {1'b0, a} + {1'b0, b};
    e.id  = id;
    e.sum = exp_timeout ? 32'h0 : t[31:0];
    e.cry = exp_timeout ? 1'b0 : t[32];
    e.err = exp_timeout;
    sb.push_back(e);
    grant_q.push_back(id);
    hs_cnt++;
  endtask

  task automatic pop(input bit id);
    sb_t e;
    if (sb.size() == 0) begin
      chk("sb_unexpected_resp", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("sb_id", id, e.id);
      chk("sb_sum", resp_sum, e.sum);
      chk("sb_cry", resp_cry, e.cry);
      chk("sb_err", resp_err, e.err);
      if (!e.err) begin
        if (e.id) begin
          if (exp_cnt1 < 3) exp_cnt1++;
        end else begin
          if (exp_cnt0 < 3) exp_cnt0++;
        end
      end
    end
    last_id  = id;
    last_sum = resp_sum;
    last_cry = resp_cry;
    last_err = resp_err;
    resp_cnt++;
  endtask

  task automatic monitor();
    if (RST_N) begin
      chk("resp_excl", resp0_valid & resp1_valid, 0);
      chk("en_needs_rdy", EN_add & ~RDY_add, 0);
      chk("ready_excl", req0_ready & req1_ready, 0);
      if (EN_add) begin
        en_cnt++;
        last_add_a = add_s_a;
        last_add_b = add_s_b;
      end
      if (req0_valid & req0_ready) push(1'b0, req0_a, req0_b);
      if (req1_valid & req1_ready) push(1'b1, req1_a, req1_b);
      if (resp0_valid & resp0_ready) pop(1'b0);
      if (resp1_valid & resp1_ready) pop(1'b1);
    end
  endtask

  // Sample mid-cycle, then return 1 time unit after the next rising edge
  task automatic tick();
    @(negedge CLK);
    monitor();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_hs(input int unsigned start);
    int unsigned k = 0;
    while (hs_cnt == start && k < 50) begin
      tick();
      k++;
    end
    chk("hs_timeout", hs_cnt != start, 1);
  endtask

  task automatic wait_resp(input int unsigned start);
    int unsigned k = 0;
    while (resp_cnt == start && k < 100) begin
      tick();
      k++;
    end
    chk("resp_timeout", resp_cnt != start, 1);
  endtask

  task automatic do_op(input bit id, input logic [31:0] a, input logic [31:0] b);
    int unsigned hs0, rs0;
    hs0 = hs_cnt;
    rs0 = resp_cnt;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b;
    end
    wait_hs(hs0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_resp(rs0);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
    exp_cnt0 = 0;
    exp_cnt1 = 0;
    sb.delete();
    grant_q.delete();
  endtask

  vec_t        vecs[8];
  int unsigned sat_exp[7];

  initial begin
    int unsigned hs0, rs0, en0, k;
    logic [31:0] held;

    vecs[0] = '{1'b0, 32'h00000001, 32'h00000002, 1, 32'h00000003, 1'b0};
    vecs[1] = '{1'b1, 32'h80000000, 32'h80000000, 3, 32'h00000000, 1'b1};
    vecs[2] = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 4, 32'h80000000, 1'b0};
    vecs[3] = '{1'b1, 32'hDEADBEEF, 32'h11111111, 1, 32'hEFBED000, 1'b0};
    vecs[4] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 32'hFFFFFFFE, 1'b1};
    vecs[5] = '{1'b0, 32'h00000000, 32'h00000000, 1, 32'h00000000, 1'b0};
    vecs[6] = '{1'b0, 32'h12345678, 32'h87654321, 5, 32'h99999999, 1'b0};
    vecs[7] = '{1'b1, 32'hFFFF0000, 32'h00010000, 2, 32'h00000000, 1'b1};
    sat_exp = '{1, 2, 3, 3, 3, 3, 3};

    RST_N = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    RDY_add = 1'b1;

    // Reset state; a request during reset is not accepted
    tick();
    req0_valid = 1'b1;
    #1;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_en_add", EN_add, 0);
    tick();
    req0_valid = 1'b0;
    RST_N = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_resp_valid", {resp1_valid, resp0_valid}, 0);
    chk("rst_resp_sum", resp_sum, 0);
    chk("rst_cnts", {cnt1, cnt0}, 0);
    chk("rst_en_after", EN_add, 0);

    // Single op: carry out of all-ones
    adder_lat = 2;
    en0 = en_cnt;
    do_op(1'b0, 32'hFFFFFFFF, 32'h00000001);
    chk("single_en_cycles", en_cnt - en0, 1);
    chk("single_add_a", last_add_a, 32'hFFFFFFFF);
    chk("single_add_b", last_add_b, 32'h00000001);
    chk("single_sum", last_sum, 32'h0);
    chk("single_cry", last_cry, 1);
    chk("single_err", last_err, 0);
    chk("single_cnt0", cnt0, 1);

    // Table-driven ops
    for (int i = 0; i < 8; i++) begin
      adder_lat = vecs[i].lat;
      do_op(vecs[i].id, vecs[i].a, vecs[i].b);
      chk("vec_add_a", last_add_a, vecs[i].a);
      chk("vec_add_b", last_add_b, vecs[i].b);
      chk("vec_id", last_id, vecs[i].id);
      chk("vec_sum", last_sum, vecs[i].sum);
      chk("vec_cry", last_cry, vecs[i].cry);
      chk("vec_cnt0", cnt0, exp_cnt0);
      chk("vec_cnt1", cnt1, exp_cnt1);
    end

    // Backpressure on RDY_add and resp0_ready, with req1 waiting
    adder_lat = 2;
    RDY_add = 1'b0;
    resp0_ready = 1'b0;
    hs0 = hs_cnt;
    rs0 = resp_cnt;
    en0 = en_cnt;
    req0_valid = 1'b1; req0_a = 32'hCAFE0001; req0_b = 32'h00001000;
    wait_hs(hs0);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'h5; req1_b = 32'h6;
    for (int i = 0; i < 5; i++) begin
      chk("bp_en_low", EN_add, 0);
      chk("bp_req1_ready", req1_ready, 0);
      tick();
    end
    chk("bp_en_none", en_cnt - en0, 0);
    RDY_add = 1'b1;
    #1;
    chk("bp_en_fire", EN_add, 1);
    tick();
    k = 0;
    while (!resp0_valid && k < 20) begin
      chk("bp_req1_ready", req1_ready, 0);
      tick();
      k++;
    end
    chk("bp_resp_valid", resp0_valid, 1);
    held = resp_sum;
    chk("bp_sum", held, 32'hCAFE1001);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_hold_valid", resp0_valid, 1);
      chk("bp_hold_sum", resp_sum, held);
      chk("bp_req1_ready", req1_ready, 0);
    end
    resp0_ready = 1'b1;
    tick();
    req1_valid = 1'b0;
    chk("bp_resp_taken", resp_cnt - rs0, 1);
    tick();
    tick();
    tick();
    chk("withdrawn_not_issued", hs_cnt - hs0, 1);
    chk("withdrawn_busy", busy, 0);

    // Timeout abort after 8 WAIT cycles
    adder_lat = 0;
    exp_timeout = 1'b1;
    resp0_ready = 1'b0;
    hs0 = hs_cnt;
    en0 = exp_cnt0;
    req0_valid = 1'b1; req0_a = 32'h1; req0_b = 32'h1;
    wait_hs(hs0);
    req0_valid = 1'b0;
    exp_timeout = 1'b0;
    tick();
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("to_resp_valid", resp0_valid, (i == 8));
    end
    chk("to_err", resp_err, 1);
    chk("to_sum", resp_sum, 0);
    chk("to_cry", resp_cry, 0);
    resp0_ready = 1'b1;
    tick();
    chk("to_cnt0", cnt0, en0);

    // Reset in WAIT abandons the op
    adder_lat = 0;
    hs0 = hs_cnt;
    rs0 = resp_cnt;
    req0_valid = 1'b1; req0_a = 32'h10; req0_b = 32'h20;
    wait_hs(hs0);
    req0_valid = 1'b0;
    tick();
    tick();
    chk("mid_busy_before", busy, 1);
    RST_N = 1'b0;
    tick();
    chk("mid_busy", busy, 0);
    chk("mid_resp_valid", {resp1_valid, resp0_valid}, 0);
    chk("mid_cnts", {cnt1, cnt0}, 0);
    RST_N = 1'b1;
    exp_cnt0 = 0;
    exp_cnt1 = 0;
    sb.delete();
    grant_q.delete();
    #1;
    chk("mid_en_after", EN_add, 0);
    chk("mid_no_resp", resp_cnt - rs0, 0);

    // Contention straight after reset: grants alternate from req0
    adder_lat = 2;
    hs0 = hs_cnt;
    rs0 = resp_cnt;
    req0_valid = 1'b1; req0_a = $urandom; req0_b = $urandom;
    req1_valid = 1'b1; req1_a = $urandom; req1_b = $urandom;
    k = 0;
    while (hs_cnt - hs0 < 6 && k < 300) begin
      en0 = hs_cnt;
      tick();
      k++;
      if (hs_cnt != en0) begin
        req0_a = $urandom; req0_b = $urandom;
        req1_a = $urandom; req1_b = $urandom;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    k = 0;
    while (resp_cnt - rs0 < 6 && k < 300) begin
      tick();
      k++;
    end
    chk("cont_resps", resp_cnt - rs0, 6);
    chk("cont_grants", grant_q.size(), 6);
    for (int i = 0; i < grant_q.size() && i < 6; i++) begin
      chk("cont_order", grant_q[i], i % 2);
    end
    chk("cont_cnt0", cnt0, 3);
    chk("cont_cnt1", cnt1, 3);

    // Saturation of a 2-bit counter
    do_reset();
    adder_lat = 1;
    for (int i = 0; i < 7; i++) begin
      do_op(1'b1, i, 32'h100);
      chk("sat_cnt1", cnt1, sat_exp[i]);
    end
    chk("sat_cnt0", cnt0, 0);
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
